wd_cmd_gen: RTL and testbench

- TX-side generator of MIPI DCS window commands.
- Takes one window (column start/end, page start/end) and emits two DCS long-write packets, 0x2A (column address set) then 0x2B (page address set), on the TX packet interface.
- Beat format matches what the RX-side window parser decodes: a 24-bit header, then 32-bit payload words with little-endian byte packing.
- Sits between the scaler/window control logic and the MIPI TX packet engine.

---
 rtl/wd_pkg.sv | 36 +++
 rtl/wd_pkt_tx.sv | 52 +++++
 rtl/wd_cmd_gen.sv | 121 ++++++++++++
 tb/tb_wd_cmd_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// wd_pkg: shared DCS constants, FSM encodings and beat packing for the window command generator.
package wd_pkg;

    localparam logic [7:0]  DCS_CASET = 8'h2A;
    localparam logic [7:0]  DCS_PASET = 8'h2B;
    localparam logic [15:0] WD_WC     = 16'h0005;

    typedef enum logic [3:0] {
        IDLE,
        HDR_A,
        PA0,
        PA1,
        GAPA,
        HDR_B,
        PB0,
        PB1,
        GAPB
    } wd_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_HDR,
        B_W0,
        B_W1
    } beat_t;

    // Little-endian byte packing: DCS byte first, then start MSB/LSB, then end MSB.
    function automatic logic [31:0] pack_w0(input logic [7:0] d, input logic [15:0] s, input logic [15:0] e);
        return {e[15:8], s[7:0], s[15:8], d};
    endfunction

    function automatic logic [31:0] pack_w1(input logic [7:0] e_lo);
        return {24'h0, e_lo};
    endfunction

endpackage

// File: rtl/wd_pkt_tx.sv
// wd_pkt_tx: emits one DCS long packet (header, word 0, word 1) over a valid/ready handshake.
module wd_pkt_tx
    import wd_pkg::*;
#(
    parameter logic [5:0] DT = 6'h39,
    parameter logic [1:0] VC = 2'd0
) (
    input  logic        clktx,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  dcs_i,
    input  logic [15:0] s_i,
    input  logic [15:0] e_i,
    input  logic        ready_i,
    output logic [23:0] cmd_o,
    output logic        cmd_valid_o,
    output logic [31:0] payload_o,
    output logic        payload_valid_o,
    output logic        last_o,
    output logic        xfer_o,
    output logic        done_o
);

    beat_t beat_q, beat_d;

    always_ff @(posedge clktx) begin
        if (!rst_n) beat_q <= B_IDLE;
        else        beat_q <= beat_d;
    end

    always_comb begin
        beat_d = beat_q;
        if (start_i) begin
            beat_d = B_HDR;
        end else if (xfer_o) begin
            case (beat_q)
                B_HDR:   beat_d = B_W0;
                B_W0:    beat_d = B_W1;
                default: beat_d = B_IDLE;
            endcase
        end
    end

    assign cmd_valid_o     = beat_q == B_HDR;
    assign payload_valid_o = beat_q == B_W0 || beat_q == B_W1;
    assign last_o          = beat_q == B_W1;
    assign cmd_o           = cmd_valid_o ? {WD_WC, VC, DT} : '0;
    assign payload_o       = beat_q == B_W0 ? pack_w0(dcs_i, s_i, e_i) : last_o ? pack_w1(e_i[7:0]) : '0;
    assign xfer_o          = (cmd_valid_o || payload_valid_o) && ready_i;
    assign done_o          = last_o && ready_i;

endmodule

// File: rtl/wd_cmd_gen.sv
// wd_cmd_gen: turns one window request into DCS 0x2A/0x2B long-write packets with inter-packet gaps.
module wd_cmd_gen
    import wd_pkg::*;
#(
    parameter logic [5:0]  DT  = 6'h39,
    parameter logic [1:0]  VC  = 2'd0,
    parameter int unsigned GAP = 4
) (
    input  logic        clktx,
    input  logic        rst_n,
    input  logic        wd_req,
    input  logic [15:0] wd_cs,
    input  logic [15:0] wd_ce,
    input  logic [15:0] wd_ps,
    input  logic [15:0] wd_pe,
    input  logic        tx_ready,
    output logic [23:0] tx_cmd,
    output logic        tx_cmd_valid,
    output logic [31:0] tx_payload,
    output logic        tx_payload_valid,
    output logic        tx_payload_valid_last,
    output logic        busy,
    output logic        wd_done,
    output logic        wd_err
);

    localparam logic [3:0] GAP_LAST = GAP == 0 ? 4'd0 : 4'(GAP - 1);

    wd_state_t   state_q, state_d;
    logic [3:0]  gap_q, gap_d;
    logic [63:0] win_q, win_d, pwin_q, pwin_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [63:0] req_win;
    logic        req_ok, in_gap, in_b, seq_end, start_seq, pkt_start, xfer, pkt_done;

    assign req_win   = {wd_cs, wd_ce, wd_ps, wd_pe};
    assign req_ok    = wd_req && wd_cs <= wd_ce && wd_ps <= wd_pe;
    assign in_gap    = state_q == GAPA || state_q == GAPB;
    assign in_b      = state_q == HDR_B || state_q == PB0 || state_q == PB1;
    // With no trailing gap the sequence ends on the PB1 transfer itself.
    assign seq_end   = GAP == 0 ? state_q == PB1 && pkt_done : state_q == GAPB && gap_q == GAP_LAST;
    assign start_seq = (req_ok && state_q == IDLE) || (seq_end && (req_ok || pend_q));
    assign pkt_start = (state_d == HDR_A && state_q != HDR_A) || (state_d == HDR_B && state_q != HDR_B);

    always_ff @(posedge clktx) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            win_q   <= '0;
            pwin_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            win_q   <= win_d;
            pwin_q  <= pwin_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = in_gap ? gap_q + 4'd1 : 4'd0;
        win_d   = win_q;
        pwin_d  = pwin_q;
        pend_d  = pend_q;
        err_d   = wd_req && !req_ok;
        done_d  = seq_end;
        case (state_q)
            HDR_A:   if (xfer) state_d = PA0;
            PA0:     if (xfer) state_d = PA1;
            PA1:     if (xfer) state_d = GAP == 0 ? HDR_B : GAPA;
            GAPA:    if (gap_q == GAP_LAST) state_d = HDR_B;
            HDR_B:   if (xfer) state_d = PB0;
            PB0:     if (xfer) state_d = PB1;
            PB1:     if (xfer) state_d = GAP == 0 ? IDLE : GAPB;
            GAPB:    if (gap_q == GAP_LAST) state_d = IDLE;
            default: ;
        endcase
        // A fresh request at sequence end is newer than the slot, so it wins.
        if (start_seq) begin
            state_d = HDR_A;
            win_d   = req_ok ? req_win : pwin_q;
            pend_d  = 1'b0;
        end else if (req_ok && state_q != IDLE) begin
            pend_d = 1'b1;
            pwin_d = req_win;
        end
    end

    wd_pkt_tx #(
        .DT(DT),
        .VC(VC)
    ) u_pkt (
        .clktx          (clktx),
        .rst_n          (rst_n),
        .start_i        (pkt_start),
        .dcs_i          (in_b ? DCS_PASET : DCS_CASET),
        .s_i            (in_b ? win_q[31:16] : win_q[63:48]),
        .e_i            (in_b ? win_q[15:0] : win_q[47:32]),
        .ready_i        (tx_ready),
        .cmd_o          (tx_cmd),
        .cmd_valid_o    (tx_cmd_valid),
        .payload_o      (tx_payload),
        .payload_valid_o(tx_payload_valid),
        .last_o         (tx_payload_valid_last),
        .xfer_o         (xfer),
        .done_o         (pkt_done)
    );

    assign busy    = state_q != IDLE;
    assign wd_done = GAP == 0 ? done_q : seq_end;
    assign wd_err  = err_q;

endmodule

// File: tb/tb_wd_cmd_gen.sv
// tb_wd_cmd_gen: scoreboard bench driving a GAP=4 and a GAP=0 instance of wd_cmd_gen.
module tb_wd_cmd_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req [2];
    logic        rdy [2];
    logic [15:0] cs, ce, ps, pe;
    logic [23:0] cmd [2];
    logic [31:0] pay [2];
    logic        cmdv [2];
    logic        payv [2];
    logic        last [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];

    wd_cmd_gen #(.GAP(4)) dut4 (
        .clktx(clk), .rst_n(rst_n), .wd_req(req[0]),
        .wd_cs(cs), .wd_ce(ce), .wd_ps(ps), .wd_pe(pe), .tx_ready(rdy[0]),
        .tx_cmd(cmd[0]), .tx_cmd_valid(cmdv[0]), .tx_payload(pay[0]),
        .tx_payload_valid(payv[0]), .tx_payload_valid_last(last[0]),
        .busy(busy[0]), .wd_done(done[0]), .wd_err(err[0])
    );

    wd_cmd_gen #(.GAP(0)) dut0 (
        .clktx(clk), .rst_n(rst_n), .wd_req(req[1]),
        .wd_cs(cs), .wd_ce(ce), .wd_ps(ps), .wd_pe(pe), .tx_ready(rdy[1]),
        .tx_cmd(cmd[1]), .tx_cmd_valid(cmdv[1]), .tx_payload(pay[1]),
        .tx_payload_valid(payv[1]), .tx_payload_valid_last(last[1]),
        .busy(busy[1]), .wd_done(done[1]), .wd_err(err[1])
    );

    // tag: 1 = final beat of 0x2A packet, 2 = final beat of 0x2B packet
    typedef struct packed {
        logic        is_cmd;
        logic [31:0] data;
        logic        last;
        logic [1:0]  tag;
    } exp_beat_t;

    exp_beat_t q0[$];
    exp_beat_t q1[$];
    int        gap_of [2]   = '{4, 0};
    int        hdrb_due [2] = '{-1, -1};
    int        done_due [2] = '{-1, -1};
    int        done_cnt [2] = '{0, 0};
    logic      held_v [2]   = '{1'b0, 1'b0};
    exp_beat_t held [2];
    int        cyc = 0;
    int        n_run = 0;
    int        n_fail = 0;
    logic      bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] w0_of(input longint d, input longint s, input longint e);
        return 32'((e / 256) * 64'h100_0000 + (s % 256) * 64'h1_0000 + (s / 256) * 256 + d);
    endfunction

    function automatic void push_pkt(input int k, input int d, input int s, input int e, input logic [1:0] tag);
        exp_beat_t b [3];
        b[0] = {1'b1, 32'(5 * 256 + 0 * 64 + 'h39), 1'b0, 2'd0};
        b[1] = {1'b0, w0_of(d, s, e), 1'b0, 2'd0};
        b[2] = {1'b0, 32'(e % 256), 1'b1, tag};
        for (int i = 0; i < 3; i++) begin
            if (k == 0) q0.push_back(b[i]);
            else        q1.push_back(b[i]);
        end
    endfunction

    function automatic void push_win(input int k, input int c_s, input int c_e, input int p_s, input int p_e);
        push_pkt(k, 'h2A, c_s, c_e, 2'd1);
        push_pkt(k, 'h2B, p_s, p_e, 2'd2);
    endfunction

    function automatic int qsize(input int k);
        return k == 0 ? q0.size() : q1.size();
    endfunction

    function automatic exp_beat_t qpop(input int k);
        return k == 0 ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic compare(input int k);
        exp_beat_t cur, b;
        logic v;
        if (!rst_n) begin
            if (k == 0) q0.delete();
            else        q1.delete();
            hdrb_due[k] = -1;
            done_due[k] = -1;
            held_v[k]   = 1'b0;
            return;
        end
        v   = cmdv[k] || payv[k];
        cur = {cmdv[k], cmdv[k] ? {8'h0, cmd[k]} : pay[k], last[k], 2'd0};
        chk($sformatf("excl_valid%0d", k), {31'd0, cmdv[k] && payv[k]}, 32'd0);
        if (held_v[k]) begin
            chk($sformatf("hold_data%0d", k), cur.data, held[k].data);
            chk($sformatf("hold_kind%0d", k), {29'd0, v, cur.is_cmd, cur.last}, {29'd0, 1'b1, held[k].is_cmd, held[k].last});
        end
        held_v[k] = v && !rdy[k];
        held[k]   = cur;
        chk($sformatf("done_time%0d", k), {31'd0, done[k]}, {31'd0, cyc == done_due[k]});
        if (done[k]) done_cnt[k]++;
        if (cyc == done_due[k]) done_due[k] = -1;
        if (hdrb_due[k] >= 0) begin
            chk($sformatf("hdrb_time%0d", k), {31'd0, cmdv[k]}, {31'd0, cyc == hdrb_due[k]});
            if (cyc == hdrb_due[k]) hdrb_due[k] = -1;
        end
        if (v && rdy[k]) begin
            chk($sformatf("beat_expected%0d", k), {31'd0, qsize(k) != 0}, 32'd1);
            if (qsize(k) != 0) begin
                b = qpop(k);
                chk($sformatf("beat_data%0d", k), cur.data, b.data);
                chk($sformatf("beat_kind%0d", k), {30'd0, cur.is_cmd, cur.last}, {30'd0, b.is_cmd, b.last});
                if (b.tag == 2'd1) hdrb_due[k] = cyc + gap_of[k] + 1;
                if (b.tag == 2'd2) done_due[k] = cyc + (gap_of[k] == 0 ? 1 : gap_of[k]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare(0);
        compare(1);
        @(posedge clk);
        #1;
        cyc++;
        if (bp_en) rdy[0] = bp_pat[cyc % 4];
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        cs = a; ce = b; ps = c; pe = d;
        req[k] = 1'b1;
        tick();
        req[k] = 1'b0;
        cs = 16'hDEAD; ce = 16'hBEEF; ps = 16'hDEAD; pe = 16'hBEEF;
    endtask

    task automatic wait_idle(input int k, input int budget);
        for (int i = 0; i < budget && (busy[k] || qsize(k) != 0 || done_due[k] >= 0); i++) tick();
        chk($sformatf("idle_busy%0d", k), {31'd0, busy[k]}, 32'd0);
        chk($sformatf("idle_drained%0d", k), qsize(k), 32'd0);
        tick();
    endtask

    task automatic busy_until_done(input int k, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt[k] < target; i++) begin
            chk($sformatf("busy_cont%0d", k), {31'd0, busy[k]}, 32'd1);
            tick();
        end
        chk($sformatf("done_count%0d", k), done_cnt[k], target);
    endtask

    initial begin
        int r, base;
        rst_n = 1'b0;
        req = '{1'b0, 1'b0};
        rdy = '{1'b1, 1'b1};
        cs = '0; ce = '0; ps = '0; pe = '0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", {31'd0, busy[k]}, 32'd0);
            chk("rst_valid", {30'd0, cmdv[k], payv[k]}, 32'd0);
            chk("rst_pulses", {30'd0, done[k], err[k]}, 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // basic 1080 window, GAP=4
        push_win(0, 0, 'h0437, 0, 'h077F);
        chk("model_hdr", q0[0].data, 32'h0000_0539);
        chk("model_a_w0", q0[1].data, 32'h0400_002A);
        chk("model_a_w1", q0[2].data, 32'h0000_0037);
        chk("model_b_w0", q0[4].data, 32'h0700_002B);
        chk("model_b_w1", q0[5].data, 32'h0000_007F);
        r = cyc;
        base = done_cnt[0];
        send(0, 16'h0000, 16'h0437, 16'h0000, 16'h077F);
        chk("basic_hdr_valid", {31'd0, cmdv[0]}, 32'd1);
        chk("basic_hdr", {8'd0, cmd[0]}, 32'h0000_0539);
        chk("basic_busy", {31'd0, busy[0]}, 32'd1);
        run_to(r + 2);
        chk("basic_w0", pay[0], 32'h0400_002A);
        run_to(r + 13);
        chk("basic_done_early", {31'd0, done[0]}, 32'd0);
        tick();
        chk("basic_done_c14", {31'd0, done[0]}, 32'd1);
        tick();
        chk("basic_idle_c15", {31'd0, busy[0]}, 32'd0);
        wait_idle(0, 50);
        chk("basic_one_done", done_cnt[0] - base, 32'd1);

        // backpressure 1,0,0,1
        push_win(0, 0, 'h0437, 0, 'h077F);
        base = done_cnt[0];
        bp_en = 1'b1;
        send(0, 16'h0000, 16'h0437, 16'h0000, 16'h077F);
        wait_idle(0, 300);
        bp_en = 1'b0;
        rdy[0] = 1'b1;
        chk("bp_one_done", done_cnt[0] - base, 32'd1);

        // invalid request: column start past end
        send(0, 16'h0100, 16'h00FF, 16'h0000, 16'h0010);
        chk("inv_err", {31'd0, err[0]}, 32'd1);
        chk("inv_busy", {31'd0, busy[0]}, 32'd0);
        tick();
        chk("inv_err_pulse", {31'd0, err[0]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("inv_no_cmd", {30'd0, cmdv[0], busy[0]}, 32'd0);
            tick();
        end

        // back-to-back: request during PA0 is superseded by one during PB0
        push_win(0, 'h10, 'h20, 'h30, 'h40);
        push_win(0, 'h0100, 'h01FF, 'h0200, 'h02FF);
        base = done_cnt[0];
        r = cyc;
        send(0, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
        run_to(r + 2);
        send(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        run_to(r + 9);
        chk("b2b_in_pb0", {31'd0, payv[0] && !last[0]}, 32'd1);
        send(0, 16'h0100, 16'h01FF, 16'h0200, 16'h02FF);
        busy_until_done(0, base + 2, 100);
        wait_idle(0, 50);

        // request coinciding with the final GAPB cycle is serviced next
        push_win(0, 'h5, 'h6, 'h7, 'h8);
        push_win(0, 'h0A0B, 'h0C0D, 'h0102, 'h0304);
        base = done_cnt[0];
        r = cyc;
        send(0, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
        run_to(r + 14);
        chk("sim_gapb_last", {31'd0, done[0]}, 32'd1);
        send(0, 16'h0A0B, 16'h0C0D, 16'h0102, 16'h0304);
        chk("sim_next_hdr", {31'd0, cmdv[0] && busy[0]}, 32'd1);
        busy_until_done(0, base + 2, 100);
        wait_idle(0, 50);

        // reset while PB0 is stalled
        push_win(0, 0, 'h0437, 0, 'h077F);
        r = cyc;
        send(0, 16'h0000, 16'h0437, 16'h0000, 16'h077F);
        run_to(r + 9);
        rdy[0] = 1'b0;
        chk("rst_pb0_data", pay[0], 32'h0700_002B);
        run_to(r + 11);
        chk("rst_pb0_held", pay[0], 32'h0700_002B);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_valid", {30'd0, cmdv[0], payv[0]}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_mid_done", {31'd0, done[0]}, 32'd0);
        rst_n = 1'b1;
        rdy[0] = 1'b1;
        tick();
        push_win(0, 0, 'h0437, 0, 'h077F);
        base = done_cnt[0];
        send(0, 16'h0000, 16'h0437, 16'h0000, 16'h077F);
        wait_idle(0, 50);
        chk("rst_resume_done", done_cnt[0] - base, 32'd1);

        // GAP=0 instance
        push_win(1, 0, 'h0437, 0, 'h077F);
        r = cyc;
        send(1, 16'h0000, 16'h0437, 16'h0000, 16'h077F);
        run_to(r + 3);
        chk("g0_pa1_last", {31'd0, last[1]}, 32'd1);
        tick();
        chk("g0_hdrb_next", {8'd0, cmd[1]}, 32'h0000_0539);
        chk("g0_hdrb_valid", {31'd0, cmdv[1]}, 32'd1);
        run_to(r + 6);
        chk("g0_done_early", {31'd0, done[1]}, 32'd0);
        tick();
        chk("g0_done_c7", {31'd0, done[1]}, 32'd1);
        wait_idle(1, 50);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
